// File: rtl/reverb_predelay_pkg.sv
// Shared types for the reverb pre-delay line: sample type and controller state encoding.
package reverb_pkg;

  localparam int DATA_W = 24;

  typedef logic signed [DATA_W-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2
  } predelay_state_t;

endpackage

// File: rtl/reverb_predelay_if.sv
// Avalon-ST style sample stream. A sample moves on every cycle where valid and ready are both high;
// the master holds data and valid stable until that happens, and ready may depend on nothing but the slave's state.
interface reverb_predelay_if #(
  parameter int DATA_W = 24
);

  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/reverb_predelay_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port, contents never reset.
module predelay_ram #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/reverb_predelay.sv
// Reverb pre-delay line: delays the input sample stream by a software-set number of samples.
// Optional macro PREDELAY_RAMP_EN slews the effective delay one sample per input to avoid clicks.
module reverb_predelay
  import reverb_pkg::*;
#(
  parameter int DATA_W = reverb_pkg::DATA_W,
  parameter int ADDR_W = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [23:0]         predelay_value,
  reverb_predelay_if.slave    sink,
  reverb_predelay_if.master   source,
  output predelay_state_t     state_dbg
);

  localparam logic [23:0]     DELAY_MAX = 24'((1 << ADDR_W) - 1);
  localparam logic [ADDR_W:0] FILL_FULL = {1'b1, {ADDR_W{1'b0}}};

  predelay_state_t   state, state_nxt;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0]   fill_cnt;
  logic [ADDR_W-1:0] delay_tgt;
  logic [ADDR_W-1:0] delay_eff;
  logic [ADDR_W-1:0] delay_q;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] in_q;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] out_q;
  logic              accept;
  logic              release_out;

  assign delay_tgt   = (predelay_value > DELAY_MAX) ? DELAY_MAX[ADDR_W-1:0]
                                                    : predelay_value[ADDR_W-1:0];
  assign accept      = sink.ready && sink.valid;
  assign release_out = (state == HOLD) && source.ready;
  assign rd_addr     = wr_ptr - delay_eff;

`ifdef PREDELAY_RAMP_EN
  logic [ADDR_W-1:0] delay_cur;

  // The value after this sample's step is the one used for the sample itself.
  always_comb begin
    delay_eff = delay_cur;
    if (delay_cur < delay_tgt) begin
      delay_eff = delay_cur + 1'b1;
    end else if (delay_cur > delay_tgt) begin
      delay_eff = delay_cur - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      delay_cur <= '0;
    end else if (accept) begin
      delay_cur <= delay_eff;
    end
  end
`else
  assign delay_eff = delay_tgt;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sink.valid)   state_nxt = READ;
      READ:    state_nxt = HOLD;
      HOLD:    if (source.ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      fill_cnt <= '0;
      delay_q  <= '0;
      in_q     <= '0;
      out_q    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        in_q    <= sink.data;
        delay_q <= delay_eff;
      end
      // fill_cnt still counts only earlier samples here, so it masks unwritten locations.
      if (state == READ) begin
        if (delay_q == '0) begin
          out_q <= in_q;
        end else if ({1'b0, delay_q} > fill_cnt) begin
          out_q <= '0;
        end else begin
          out_q <= rd_data;
        end
      end
      if (release_out) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (fill_cnt != FILL_FULL) begin
          fill_cnt <= fill_cnt + 1'b1;
        end
      end
    end
  end

  predelay_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (accept),
    .waddr (wr_ptr),
    .wdata (sink.data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  assign sink.ready   = (state == IDLE) && !reset;
  assign source.valid = (state == HOLD);
  assign source.data  = out_q;
  assign state_dbg    = state;

endmodule

// File: tb/tb_reverb_predelay.sv
// Drives a 4096-deep and a 16-deep pre-delay line with identical stimulus and checks both against a sample-history model.
module tb_reverb_predelay;
  import reverb_pkg::*;

  // clock / reset
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] predelay_value = '0;
  predelay_state_t st12, st4;

  always #5 clk = ~clk;

  reverb_predelay_if #(.DATA_W(24)) s12 ();
  reverb_predelay_if #(.DATA_W(24)) o12 ();
  reverb_predelay_if #(.DATA_W(24)) s4 ();
  reverb_predelay_if #(.DATA_W(24)) o4 ();

  reverb_predelay #(.DATA_W(24), .ADDR_W(12)) dut12 (
    .clk            (clk),
    .reset          (reset),
    .predelay_value (predelay_value),
    .sink           (s12),
    .source         (o12),
    .state_dbg      (st12)
  );

  reverb_predelay #(.DATA_W(24), .ADDR_W(4)) dut4 (
    .clk            (clk),
    .reset          (reset),
    .predelay_value (predelay_value),
    .sink           (s4),
    .source         (o4),
    .state_dbg      (st4)
  );

  // scoreboard
  int          n_checks = 0;
  int          n_errors = 0;
  logic [23:0] exp12_q[$];
  logic [23:0] exp4_q[$];
  logic [23:0] hist[$];
  int          cur[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int tgt_of(input int aw, input logic [23:0] pv);
    int mx;
    mx = (1 << aw) - 1;
    return (int'(pv) > mx) ? mx : int'(pv);
  endfunction

  task automatic model_reset();
    hist.delete();
    exp12_q.delete();
    exp4_q.delete();
    cur[0] = 0;
    cur[1] = 0;
  endtask

  // Output of a sample = the sample delay_eff positions back in the history, 0 if none yet.
  task automatic model_accept(input logic [23:0] s);
    for (int k = 0; k < 2; k++) begin
      int          aw;
      int          t;
      int          eff;
      logic [23:0] e;
      aw = (k == 0) ? 12 : 4;
      t  = tgt_of(aw, predelay_value);
`ifdef PREDELAY_RAMP_EN
      if (cur[k] < t) cur[k]++;
      else if (cur[k] > t) cur[k]--;
      eff = cur[k];
`else
      eff = t;
`endif
      if (eff == 0) e = s;
      else if (eff > hist.size()) e = '0;
      else e = hist[hist.size() - eff];
      if (k == 0) exp12_q.push_back(e);
      else exp4_q.push_back(e);
    end
    hist.push_back(s);
  endtask

  // drivers
  task automatic set_sink(input logic v, input logic [23:0] d);
    s12.valid = v;
    s4.valid  = v;
    s12.data  = d;
    s4.data   = d;
  endtask

  task automatic set_src_ready(input logic r);
    o12.ready = r;
    o4.ready  = r;
  endtask

  task automatic wait_idle();
    int waited;
    waited = 0;
    while (!(s12.ready && s4.ready) && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check("sink_ready_idle", {30'd0, s12.ready, s4.ready}, 32'd3);
  endtask

  task automatic xfer(input logic [23:0] s, input int stall, input bit chg);
    logic [23:0] e12;
    logic [23:0] e4;
    wait_idle();
    set_sink(1'b1, s);
    set_src_ready(stall == 0);
    model_accept(s);
    @(negedge clk);
    set_sink(1'b0, 24'($urandom));
    if (chg) predelay_value = 24'($urandom_range(0, 20));
    check("valid_read_cycle", {30'd0, o12.valid, o4.valid}, 32'd0);
    @(negedge clk);
    check("valid_hold_cycle", {30'd0, o12.valid, o4.valid}, 32'd3);
    e12 = exp12_q.pop_front();
    e4  = exp4_q.pop_front();
    check("data12", o12.data, e12);
    check("data4", o4.data, e4);
    for (int i = 0; i < stall; i++) begin
      set_sink(1'b1, 24'($urandom));
      @(negedge clk);
      check("stall_data12", o12.data, e12);
      check("stall_data4", o4.data, e4);
      check("stall_valid", {30'd0, o12.valid, o4.valid}, 32'd3);
      check("stall_sink_ready", {30'd0, s12.ready, s4.ready}, 32'd0);
      if (i == stall - 1) begin
        set_src_ready(1'b1);
        set_sink(1'b0, 24'd0);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    set_sink(1'b0, 24'd0);
    set_src_ready(1'b1);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_sink_ready", {30'd0, s12.ready, s4.ready}, 32'd0);
    check("rst_source_valid", {30'd0, o12.valid, o4.valid}, 32'd0);
    check("rst_source_data12", o12.data, 32'd0);
    check("rst_source_data4", o4.data, 32'd0);
    check("rst_state", {28'd0, st12, st4}, {28'd0, IDLE, IDLE});
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    check("first_ready_after_rst", {30'd0, s12.ready, s4.ready}, 32'd3);

    // delay 4, samples 1..10
    predelay_value = 24'd4;
    for (int i = 1; i <= 10; i++) xfer(24'(i), 0, 1'b0);

    // bypass with extreme values
    predelay_value = 24'd0;
    xfer(24'h7FFFFF, 0, 1'b0);
    xfer(24'h800000, 0, 1'b0);
    xfer(24'h000001, 0, 1'b0);

    // clamp to depth-1 and pointer wrap on the small buffer
    predelay_value = 24'hFFFFFF;
    for (int i = 1; i <= 40; i++) xfer(24'(i), 0, 1'b0);

    // backpressure
    predelay_value = 24'd2;
    xfer(24'h000100, 5, 1'b0);
    xfer(24'h000101, 0, 1'b0);
    xfer(24'h000102, 3, 1'b0);

    // reset while an output is pending
    predelay_value = 24'd3;
    for (int i = 0; i < 20; i++) xfer(24'($urandom), 0, 1'b0);
    wait_idle();
    set_sink(1'b1, 24'h0ABCDE);
    set_src_ready(1'b0);
    @(negedge clk);
    set_sink(1'b0, 24'd0);
    @(negedge clk);
    check("pre_reset_valid", {30'd0, o12.valid, o4.valid}, 32'd3);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_source_valid", {30'd0, o12.valid, o4.valid}, 32'd0);
    check("midrst_sink_ready", {30'd0, s12.ready, s4.ready}, 32'd0);
    check("midrst_source_data", {8'd0, o12.data}, 32'd0);
    reset = 1'b0;
    set_src_ready(1'b1);
    model_reset();
    for (int i = 0; i < 6; i++) xfer(24'(24'h300 + i), 0, 1'b0);

    // delay step 0 -> 5
    predelay_value = 24'd0;
    for (int i = 0; i < 4; i++) xfer(24'(24'h400 + i), 0, 1'b0);
    predelay_value = 24'd5;
    for (int i = 0; i < 8; i++) xfer(24'(24'h500 + i), 0, 1'b0);

    // randomized traffic
    for (int i = 0; i < 150; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) predelay_value = 24'hFFFFFF;
      else if (r == 1) predelay_value = 24'($urandom);
      else if (r < 5) predelay_value = 24'($urandom_range(0, 20));
      xfer(24'($urandom), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
           $urandom_range(0, 4) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
